gate_a_collision_detect: RTL and testbench

// - Downstream consumer of the gate A sprite drawer's registered draw request.
// - Detects per-frame pixel overlap between the frog sprite and gate A.
// - Reports one collision pulse per hit to the game controller, then holds off re-triggering.
// - Runs in the VGA pixel-clock domain, in parallel with the RGB priority mux.

---
 rtl/gate_a_collision_detect.sv | 134 +++++++++++++
 tb/tb_gate_a_collision_detect.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_a_collision_detect.sv
// Frog / gate A per-frame overlap detector: one collision pulse per hit, then a frame holdoff.
// Build option COLL_EARLY_HIT_EN: fire mid-frame as soon as the overlap count reaches MIN_PIXELS.
module gate_a_collision_detect #(
    parameter int MIN_PIXELS     = 4,
    parameter int CNT_W          = 11,
    parameter int HOLDOFF_FRAMES = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             enable,
    input  logic             startOfFrame,
    input  logic             frog_draw_req,
    input  logic             gateA_draw_req,
    output logic             collision,
    output logic             armed,
    output logic [CNT_W-1:0] overlap_count,
    output logic [7:0]       hit_total
);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, ARMED, HOLDOFF} state_t;

    localparam int               HOLD_W    = (HOLDOFF_FRAMES < 1) ? 1 : $clog2(HOLDOFF_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLDOFF_FRAMES);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  MIN_CNT   = CNT_W'(MIN_PIXELS);

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d, cnt_next, ovl_d;
    logic [HOLD_W-1:0] holdoff, holdoff_d;
    logic              skip_dec, skip_dec_d;
    logic              coll_d;
    logic [7:0]        hit_total_d;
    logic              sample, hit, holdoff_step;

    assign sample = frog_draw_req & gateA_draw_req;

    // The cycle that carries startOfFrame belongs to the new frame.
    always_comb begin
        if (startOfFrame)
            cnt_next = sample ? CNT_W'(1) : '0;
        else if (sample && cnt != CNT_MAX)
            cnt_next = cnt + CNT_W'(1);
        else
            cnt_next = cnt;
    end

`ifdef COLL_EARLY_HIT_EN
    assign hit = enable && state == ARMED && sample && cnt_next == MIN_CNT
                 && (startOfFrame || cnt != MIN_CNT);
`else
    assign hit = enable && state == ARMED && startOfFrame && cnt >= MIN_CNT;
`endif

    assign holdoff_step = state == HOLDOFF && startOfFrame && !skip_dec;

    // State register; armed is decoded from the next state so it lines up with state.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (RESET) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_d;
            armed <= (state_d == ARMED);
        end
    end

    // Next-state logic; enable low overrides everything.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE:     state_d = WAIT_SOF;
                WAIT_SOF: if (startOfFrame) state_d = ARMED;
                ARMED:    if (hit && HOLDOFF_FRAMES != 0) state_d = HOLDOFF;
                HOLDOFF:  if (holdoff_step && holdoff <= HOLD_W'(1)) state_d = ARMED;
                default:  state_d = IDLE;
            endcase
        end
    end

    // Datapath and output next values.
    always_comb begin
        cnt_d       = cnt;
        ovl_d       = overlap_count;
        holdoff_d   = holdoff;
        skip_dec_d  = skip_dec;
        coll_d      = hit;
        hit_total_d = (hit && hit_total != 8'hFF) ? hit_total + 8'd1 : hit_total;

        if (!enable || state == IDLE) begin
            cnt_d      = '0;
            holdoff_d  = '0;
            skip_dec_d = 1'b0;
        end else begin
            cnt_d = cnt_next;
            if (startOfFrame) begin
                ovl_d      = cnt;
                skip_dec_d = 1'b0;
            end
            if (hit) begin
                holdoff_d = HOLD_INIT;
`ifdef COLL_EARLY_HIT_EN
                // The frame that produced the hit ends at the next SOF and does not count as holdoff.
                skip_dec_d = 1'b1;
`endif
            end else if (holdoff_step && holdoff != '0) begin
                holdoff_d = holdoff - HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt           <= '0;
            overlap_count <= '0;
            holdoff       <= '0;
            skip_dec      <= 1'b0;
            collision     <= 1'b0;
            hit_total     <= '0;
        end else begin
            cnt           <= cnt_d;
            overlap_count <= ovl_d;
            holdoff       <= holdoff_d;
            skip_dec      <= skip_dec_d;
            collision     <= coll_d;
            hit_total     <= hit_total_d;
        end
    end

endmodule

// File: tb/tb_gate_a_collision_detect.sv
// Directed self-checking bench for gate_a_collision_detect (MIN_PIXELS=4, HOLDOFF_FRAMES=2).
module tb_gate_a_collision_detect;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        enable = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        frog_draw_req = 1'b0;
    logic        gateA_draw_req = 1'b0;
    logic        collision;
    logic        armed;
    logic [10:0] overlap_count;
    logic [7:0]  hit_total;

    int checks = 0;
    int errors = 0;

    gate_a_collision_detect #(.MIN_PIXELS(4), .CNT_W(11), .HOLDOFF_FRAMES(2)) dut (
        .CLK(CLK), .RESET(RESET), .enable(enable), .startOfFrame(startOfFrame),
        .frog_draw_req(frog_draw_req), .gateA_draw_req(gateA_draw_req),
        .collision(collision), .armed(armed),
        .overlap_count(overlap_count), .hit_total(hit_total)
    );

    always #5 CLK = ~CLK;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic drive(input logic sof, input logic fr, input logic ga);
        startOfFrame   = sof;
        frog_draw_req  = fr;
        gateA_draw_req = ga;
        @(posedge CLK);
        #1;
    endtask

    // n overlapping pixels, each followed by frog-only, gate-only and empty pixels.
    task automatic body(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b1, 1'b1);
            drive(1'b0, 1'b1, 1'b0);
            drive(1'b0, 1'b0, 1'b1);
            drive(1'b0, 1'b0, 1'b0);
        end
        drive(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset;
        enable = 1'b1;
        RESET  = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1);
        checks += 4;
        if (collision !== 1'b0) begin errors++; $display("FAIL reset_collision: got %b want 0", collision); end
        if (armed !== 1'b0) begin errors++; $display("FAIL reset_armed: got %b want 0", armed); end
        if (overlap_count !== 11'd0) begin errors++; $display("FAIL reset_overlap: got %0d want 0", overlap_count); end
        if (hit_total !== 8'd0) begin errors++; $display("FAIL reset_hit_total: got %0d want 0", hit_total); end
    endtask

    task automatic test_arm_mid_frame;
        RESET = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 1'b1);
            drive(1'b0, 1'b0, 1'b1);
            checks += 2;
            if (collision !== 1'b0) begin errors++; $display("FAIL arm_partial_collision: got %b want 0", collision); end
            if (armed !== 1'b0) begin errors++; $display("FAIL arm_partial_armed: got %b want 0", armed); end
        end
        drive(1'b1, 1'b0, 1'b0);
        checks += 3;
        if (collision !== 1'b0) begin errors++; $display("FAIL arm_sof_collision: got %b want 0", collision); end
        if (armed !== 1'b1) begin errors++; $display("FAIL arm_sof_armed: got %b want 1", armed); end
        if (overlap_count !== 11'd10) begin errors++; $display("FAIL arm_sof_overlap: got %0d want 10", overlap_count); end
    endtask

    task automatic test_below_threshold;
        body(3);
        drive(1'b1, 1'b0, 1'b0);
        checks += 3;
        if (collision !== 1'b0) begin errors++; $display("FAIL below_collision: got %b want 0", collision); end
        if (overlap_count !== 11'd3) begin errors++; $display("FAIL below_overlap: got %0d want 3", overlap_count); end
        if (armed !== 1'b1) begin errors++; $display("FAIL below_armed: got %b want 1", armed); end
    endtask

`ifdef COLL_EARLY_HIT_EN
    task automatic test_early_hit;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1);
            checks++;
            if (collision !== 1'b0) begin errors++; $display("FAIL early_pre_collision: got %b want 0", collision); end
        end
        drive(1'b0, 1'b1, 1'b1);
        checks += 3;
        if (collision !== 1'b1) begin errors++; $display("FAIL early_collision: got %b want 1", collision); end
        if (armed !== 1'b0) begin errors++; $display("FAIL early_armed: got %b want 0", armed); end
        if (hit_total !== 8'd1) begin errors++; $display("FAIL early_hit_total: got %0d want 1", hit_total); end
        drive(1'b0, 1'b1, 1'b1);
        checks++;
        if (collision !== 1'b0) begin errors++; $display("FAIL early_pulse_width: got %b want 0", collision); end
        drive(1'b1, 1'b0, 1'b0);
        checks += 4;
        if (collision !== 1'b0) begin errors++; $display("FAIL early_sof_collision: got %b want 0", collision); end
        if (hit_total !== 8'd1) begin errors++; $display("FAIL early_sof_hit_total: got %0d want 1", hit_total); end
        if (overlap_count !== 11'd5) begin errors++; $display("FAIL early_sof_overlap: got %0d want 5", overlap_count); end
        if (armed !== 1'b0) begin errors++; $display("FAIL early_sof_armed: got %b want 0", armed); end
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (armed !== 1'b0) begin errors++; $display("FAIL early_hold1_armed: got %b want 0", armed); end
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (armed !== 1'b1) begin errors++; $display("FAIL early_rearm: got %b want 1", armed); end
    endtask
`else
    task automatic test_hit;
        body(9);
        drive(1'b1, 1'b0, 1'b0);
        checks += 4;
        if (collision !== 1'b1) begin errors++; $display("FAIL hit_collision: got %b want 1", collision); end
        if (overlap_count !== 11'd9) begin errors++; $display("FAIL hit_overlap: got %0d want 9", overlap_count); end
        if (hit_total !== 8'd1) begin errors++; $display("FAIL hit_total: got %0d want 1", hit_total); end
        if (armed !== 1'b0) begin errors++; $display("FAIL hit_armed: got %b want 0", armed); end
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (collision !== 1'b0) begin errors++; $display("FAIL hit_pulse_width: got %b want 0", collision); end
    endtask

    task automatic test_holdoff;
        body(9);
        drive(1'b1, 1'b0, 1'b0);
        checks += 4;
        if (collision !== 1'b0) begin errors++; $display("FAIL hold1_collision: got %b want 0", collision); end
        if (armed !== 1'b0) begin errors++; $display("FAIL hold1_armed: got %b want 0", armed); end
        if (overlap_count !== 11'd9) begin errors++; $display("FAIL hold1_overlap: got %0d want 9", overlap_count); end
        if (hit_total !== 8'd1) begin errors++; $display("FAIL hold1_hit_total: got %0d want 1", hit_total); end
        body(9);
        drive(1'b1, 1'b0, 1'b0);
        checks += 3;
        if (collision !== 1'b0) begin errors++; $display("FAIL hold2_collision: got %b want 0", collision); end
        if (armed !== 1'b1) begin errors++; $display("FAIL hold2_armed: got %b want 1", armed); end
        if (hit_total !== 8'd1) begin errors++; $display("FAIL hold2_hit_total: got %0d want 1", hit_total); end
        body(9);
        drive(1'b1, 1'b0, 1'b0);
        checks += 2;
        if (collision !== 1'b1) begin errors++; $display("FAIL rehit_collision: got %b want 1", collision); end
        if (hit_total !== 8'd2) begin errors++; $display("FAIL rehit_hit_total: got %0d want 2", hit_total); end
    endtask

    task automatic test_sof_overlap;
        body(2);
        drive(1'b1, 1'b1, 1'b1);
        checks++;
        if (overlap_count !== 11'd2) begin errors++; $display("FAIL sofov_old_frame: got %0d want 2", overlap_count); end
        body(2);
        drive(1'b1, 1'b0, 1'b0);
        checks += 3;
        if (overlap_count !== 11'd3) begin errors++; $display("FAIL sofov_new_frame: got %0d want 3", overlap_count); end
        if (armed !== 1'b1) begin errors++; $display("FAIL sofov_armed: got %b want 1", armed); end
        if (collision !== 1'b0) begin errors++; $display("FAIL sofov_collision: got %b want 0", collision); end
    endtask

    task automatic test_enable_drop;
        body(9);
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (hit_total !== 8'd3) begin errors++; $display("FAIL drop_pre_hit_total: got %0d want 3", hit_total); end
        body(2);
        enable = 1'b0;
        drive(1'b0, 1'b1, 1'b1);
        checks += 4;
        if (armed !== 1'b0) begin errors++; $display("FAIL drop_armed: got %b want 0", armed); end
        if (collision !== 1'b0) begin errors++; $display("FAIL drop_collision: got %b want 0", collision); end
        if (overlap_count !== 11'd9) begin errors++; $display("FAIL drop_overlap_hold: got %0d want 9", overlap_count); end
        if (hit_total !== 8'd3) begin errors++; $display("FAIL drop_hit_total_hold: got %0d want 3", hit_total); end
        drive(1'b1, 1'b1, 1'b1);
        checks++;
        if (overlap_count !== 11'd9) begin errors++; $display("FAIL idle_sof_overlap: got %0d want 9", overlap_count); end
        enable = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        body(5);
        drive(1'b1, 1'b0, 1'b0);
        checks += 3;
        if (armed !== 1'b1) begin errors++; $display("FAIL rearm_armed: got %b want 1", armed); end
        if (collision !== 1'b0) begin errors++; $display("FAIL rearm_collision: got %b want 0", collision); end
        if (overlap_count !== 11'd5) begin errors++; $display("FAIL rearm_overlap: got %0d want 5", overlap_count); end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 252; i++) begin
            body(4);
            drive(1'b1, 1'b0, 1'b0);
            drive(1'b1, 1'b0, 1'b0);
            drive(1'b1, 1'b0, 1'b0);
        end
        checks += 2;
        if (hit_total !== 8'd255) begin errors++; $display("FAIL sat_reach: got %0d want 255", hit_total); end
        if (armed !== 1'b1) begin errors++; $display("FAIL sat_armed: got %b want 1", armed); end
        body(4);
        drive(1'b1, 1'b0, 1'b0);
        checks += 2;
        if (collision !== 1'b1) begin errors++; $display("FAIL sat_collision: got %b want 1", collision); end
        if (hit_total !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d want 255", hit_total); end
    endtask
`endif

    task automatic test_reset_mid_frame;
        body(3);
        RESET = 1'b1;
        drive(1'b0, 1'b1, 1'b1);
        checks += 3;
        if (armed !== 1'b0) begin errors++; $display("FAIL rstmid_armed: got %b want 0", armed); end
        if (hit_total !== 8'd0) begin errors++; $display("FAIL rstmid_hit_total: got %0d want 0", hit_total); end
        if (overlap_count !== 11'd0) begin errors++; $display("FAIL rstmid_overlap: got %0d want 0", overlap_count); end
        RESET = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        body(5);
        checks++;
        if (armed !== 1'b0) begin errors++; $display("FAIL rstmid_wait_armed: got %b want 0", armed); end
        drive(1'b1, 1'b0, 1'b0);
        checks += 3;
        if (armed !== 1'b1) begin errors++; $display("FAIL rstmid_rearm: got %b want 1", armed); end
        if (collision !== 1'b0) begin errors++; $display("FAIL rstmid_collision: got %b want 0", collision); end
        if (overlap_count !== 11'd5) begin errors++; $display("FAIL rstmid_rearm_overlap: got %0d want 5", overlap_count); end
    endtask

    initial begin
        test_reset();
        test_arm_mid_frame();
        test_below_threshold();
`ifdef COLL_EARLY_HIT_EN
        test_early_hit();
`else
        test_hit();
        test_holdoff();
        test_sof_overlap();
        test_enable_drop();
        test_saturation();
`endif
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
